// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide share one hi/lo register pair.
// An accepted request spends one CALC cycle taking operand magnitudes (and taking
// the early exit for divide-by-zero / signed overflow), then DATA_WIDTH iterations,
// then one FIX cycle that applies the result sign, then waits in DONE.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE, and while it
// is high result is held stable until out_ready is seen. flush and rst override both.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter bit EARLY_OUT  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            setup;     // first CALC cycle: load magnitudes, decide early exit
  logic [CW-1:0]   cnt;       // iteration counter 0..W-1
  logic [W-1:0]    hi;        // product high half / partial remainder
  logic [W-1:0]    lo;        // multiplier then product low half / dividend then quotient
  logic [W-1:0]    opnd;      // multiplicand / divisor magnitude
  logic            neg_main;  // negate product or quotient in FIX
  logic            neg_rem;   // negate remainder in FIX

  // operand decode
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            sa;
  logic            sb;
  logic [W-1:0]    a_abs;
  logic [W-1:0]    b_abs;
  logic            b_zero;
  logic            ovf;
  logic            early;
  logic [W-1:0]    early_val;
  logic [W-1:0]    min_neg;

  // datapath
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic [W:0]      div_diff;
  logic [2*W-1:0]  prod;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix;
  logic [W-1:0]    rem_fix;
  logic [W-1:0]    fix_val;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Decode signedness, magnitudes and the divide special cases from the captured request.
  always_comb begin
    min_neg   = {1'b1, {(W-1){1'b0}}};
    is_div    = op_q[2];
    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed
    a_signed  = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10);
    b_signed  = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01);
    sa        = a_signed & a_q[W-1];
    sb        = b_signed & b_q[W-1];
    a_abs     = sa ? (~a_q + 1'b1) : a_q;
    b_abs     = sb ? (~b_q + 1'b1) : b_q;
    b_zero    = (b_q == '0);
    ovf       = is_div & ~op_q[0] & (a_q == min_neg) & (b_q == {W{1'b1}});
    early     = EARLY_OUT & is_div & (b_zero | ovf);
    early_val = '0;
    if (b_zero) begin
      early_val = op_q[1] ? a_q : {W{1'b1}};
    end else if (ovf) begin
      early_val = op_q[1] ? '0 : min_neg;
    end
  end

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    div_shift = {hi, lo[W-1]};
    div_diff  = div_shift - {1'b0, opnd};
  end

  // Sign correction and result selection for the FIX cycle.
  always_comb begin
    prod     = {hi, lo};
    prod_fix = neg_main ? (~prod + 1'b1) : prod;
    quo_fix  = neg_main ? (~lo + 1'b1) : lo;
    rem_fix  = neg_rem ? (~hi + 1'b1) : hi;
    fix_val  = '0;
    case (op_q)
      3'b000:                 fix_val = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*W-1:W];
      3'b100, 3'b101:         fix_val = quo_fix;
      default:                fix_val = rem_fix;
    endcase
  end

  // Control FSM and datapath registers; flush beats everything except reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      setup     <= 1'b0;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      setup     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            setup <= 1'b1;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (setup) begin
            setup <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            if (is_div) begin
              lo       <= a_abs;
              opnd     <= b_abs;
              neg_main <= (sa ^ sb) & ~b_zero;
              neg_rem  <= sa;
            end else begin
              lo       <= b_abs;
              opnd     <= a_abs;
              neg_main <= sa ^ sb;
              neg_rem  <= 1'b0;
            end
            if (early) begin
              result    <= early_val;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end else begin
            if (is_div) begin
              if (!div_diff[W]) begin
                hi <= div_diff[W-1:0];
                lo <= {lo[W-2:0], 1'b1};
              end else begin
                hi <= div_shift[W-1:0];
                lo <= {lo[W-2:0], 1'b0};
              end
            end else begin
              hi <= mul_sum[W:1];
              lo <= {mul_sum[0], lo[W-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(W-1)) begin
              state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          result    <= fix_val;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model of the RV32M multiply/divide instructions.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  muldiv_unit #(.DATA_WIDTH(32), .EARLY_OUT(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32M semantics in plain 64-bit / integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                            input logic [31:0] y);
    logic [63:0] sx;
    logic [63:0] sy;
    logic [63:0] ux;
    logic [63:0] uy;
    logic [63:0] p;
    int          ix;
    int          iy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    ix = x;
    iy = y;
    case (f)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        return ix / iy;
      end
      3'd5: begin
        if (y == 0) return 32'hFFFFFFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        return ix % iy;
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] x,
                                     input logic [31:0] y);
    if (f[2] && (y == 0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)))
      return 1;
    return 34;
  endfunction

  // Issue one request, wait for out_valid (bounded), return result and cycle count.
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    chk("in_ready_before_issue", in_ready, 1'b1);
    in_valid = 1'b1;
    op = f;
    a = x;
    b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  // Complete the output handshake and confirm return to IDLE.
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_in_ready", in_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y);
    logic [31:0] res;
    int lat;
    issue(f, x, y, res, lat);
    chk({tag, "_latency"}, lat, exp_latency(f, x, y));
    chk({tag, "_result"}, res, ref_model(f, x, y));
    drain();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    int lat;
    int seen;
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    op        = 3'd0;
    a         = '0;
    b         = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // reset state
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // directed cases
    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD);
    run_op("mulhu_ones", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mulh_ones", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mulhsu_m1_2", 3'd2, 32'hFFFFFFFF, 32'd2);
    run_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2);
    run_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    run_op("divu_by0", 3'd5, 32'h1234, 32'h0);
    run_op("remu_by0", 3'd7, 32'h1234, 32'h0);
    run_op("div_by0", 3'd4, 32'hFFFFFFF0, 32'h0);
    run_op("rem_by0", 3'd6, 32'hFFFFFFF0, 32'h0);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF);
    run_op("divu_minneg_m1", 3'd5, 32'h80000000, 32'hFFFFFFFF);

    // output back-pressure: hold out_ready low for 5 cycles
    issue(3'd3, 32'hDEADBEEF, 32'h12345678, res, lat);
    chk("hold_latency", lat, 34);
    held = res;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_result", result, held);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    chk("hold_value", held, ref_model(3'd3, 32'hDEADBEEF, 32'h12345678));
    drain();

    // flush during iteration 10
    in_valid = 1'b1;
    op = 3'd0;
    a = 32'h00001111;
    b = 32'h00002222;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) begin
      @(posedge clk); #1;
    end
    chk("pre_flush_busy", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_result_kept", result, held);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush_no_out_valid", seen, 0);

    // request together with flush is not accepted
    in_valid = 1'b1;
    flush = 1'b1;
    op = 3'd5;
    a = 32'd50;
    b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_req_in_ready", in_ready, 1'b1);
    chk("flush_req_busy", busy, 1'b0);

    // asynchronous reset mid-CALC
    in_valid = 1'b1;
    op = 3'd1;
    a = 32'h76543210;
    b = 32'h89ABCDEF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_result", result, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op("mul_3_5", 3'd0, 32'd3, 32'd5);

    // randomized operations with random output back-pressure
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f;
      logic [31:0] x;
      logic [31:0] y;
      int          wait_cycles;
      f = 3'($urandom_range(0, 7));
      x = rand_operand();
      y = rand_operand();
      issue(f, x, y, res, lat);
      chk("rand_latency", lat, exp_latency(f, x, y));
      chk("rand_result", res, ref_model(f, x, y));
      wait_cycles = $urandom_range(0, 3);
      for (int i = 0; i < wait_cycles; i++) begin
        @(posedge clk); #1;
        chk("rand_hold", result, res);
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
